cpu_run_monitor: RTL and testbench
==================================

# cpu_run_monitor

Synthesizable run controller and post-mortem dumper for the A09 CPU. It sequences the CPU through reset and waits for ready. It checks that program memory is loaded, then counts cycles and instructions until Halt or a watchdog timeout. Finally it streams register-file and memory contents plus a summary word over a valid/ready port. It sits beside the CPU at SoC top level and replaces bench-only sequencing with hardware usable on FPGA.

## Interface
- DataWidth, 16, CPU data width
- AddrWidth, 8, memory address width
- RegCount, 8, register-file entries dumped (power of 2, ≥2)
- MemDumpDepth, 15, memory words dumped starting at address 0 (1..2^AddrWidth)
- ResetHold, 2, cycles CpuResetN is held low (≥1)
- WatchdogCycles, 5000, RUN cycles before Timeout (≥1)
- CountWidth, 32, cycle/instruction counter width

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high
- Start  in  1  begin a run; sampled only in IDLE, DONE, ERROR
- CpuReady  in  1  CPU control matrix is in its ready state
- InstrStart  in  1  one-cycle pulse at each instruction fetch start
- CpuHalt  in  1  CPU halt level
- CpuResetN  out  1  active-low reset to the CPU
- RegAddr  out  log2(RegCount)  register-file read address
- RegData  in  DataWidth  combinational register read data
- MemAddr  out  AddrWidth  memory read address
- MemData  in  DataWidth  combinational memory read data
- DumpValid  out  1  dump beat valid
- DumpReady  in  1  sink accepts beat
- DumpData  out  DataWidth  beat payload
- DumpKind  out  2  0 = register, 1 = memory, 2 = summary
- DumpIndex  out  AddrWidth  register/memory index of beat (0 for summary)
- Busy  out  1  run or dump in progress
- Done  out  1  dump finished
- Timeout  out  1  watchdog expired during last run
- Error  out  1  memory not loaded
- CycleCount  out  CountWidth  RUN cycles of last run
- InstrCount  out  CountWidth  InstrStart pulses seen in RUN

## Operation
- States:
  - IDLE: on Start go to HOLD.
  - HOLD: CpuResetN=0 for ResetHold cycles, then go to WAIT_READY.
  - WAIT_READY: wait for CpuReady=1, then go to CHECK.
  - CHECK: one cycle, MemAddr=0. If MemData==0, go to ERROR; else go to RUN.
  - RUN: see RUN bullet.
  - DUMP_REG: see dump bullet; then go to DUMP_MEM.
  - DUMP_MEM: see dump bullet; then go to DUMP_SUM.
  - DUMP_SUM: see dump bullet; then go to DONE.
  - DONE, ERROR: on Start go to HOLD.
- Start accepted clears CycleCount, InstrCount, Timeout, Error, and Done.
- CpuResetN is 0 in IDLE and HOLD, and 1 in all other states. ERROR and DONE keep the CPU out of reset.
- RUN: CycleCount +1 every cycle and InstrCount +1 per InstrStart. Both saturate at all-ones.
- RUN exit: CpuHalt=1 goes to DUMP_REG. CycleCount reaching WatchdogCycles with no halt sets Timeout=1 and goes to DUMP_REG.
- RUN exit priority: halt and watchdog expiry in the same cycle means halt wins, Timeout=0.
- Dumps: RegCount beats (kind 0, index 0..RegCount-1), then MemDumpDepth beats (kind 1, index 0..MemDumpDepth-1), then one summary beat (kind 2, data = InstrCount[DataWidth-1:0]).
- Dump addressing: RegAddr/MemAddr present the next index to be loaded. DumpData/Kind/Index are registered, loaded when !DumpValid || DumpReady.
- Busy=1 in HOLD through DUMP_SUM. Done=1 only in DONE. Error=1 only in ERROR.
- Outputs other than DumpValid/Busy/Done/Error/CpuResetN hold their last values outside their active states.

## Timing
- Reset values:
  - state=IDLE
  - CpuResetN=0
  - DumpValid=0; DumpData, DumpKind, DumpIndex=0
  - RegAddr, MemAddr=0
  - Busy, Done, Timeout, Error=0
  - CycleCount, InstrCount=0
- Reset is asynchronous and takes effect immediately mid-run or mid-dump. A beat in flight is dropped: DumpValid falls without handshake.
- Start to CpuResetN low: already low; CpuResetN rises exactly ResetHold cycles after Start is sampled.
- CpuReady to RUN: 2 cycles (CHECK is exactly 1 cycle).
- Halt sampled in RUN: DumpValid=1 on the following cycle with register 0.
- Handshake: a beat transfers on a rising edge with DumpValid&&DumpReady.
- While DumpValid&&!DumpReady, all Dump* outputs are stable.
- With DumpReady held high there are no bubbles: total dump = RegCount+MemDumpDepth+1 consecutive cycles.
- Summary beat accepted: next cycle Done=1, Busy=0, DumpValid=0.
- CpuHalt and InstrStart are ignored outside RUN. CpuReady is ignored outside WAIT_READY.
- CycleCount counts the halt-detect cycle, so a halt on the first RUN cycle gives CycleCount=1.

## Test plan
- Normal run: Start, CpuReady after 3 cycles, mem[0]=0x1234, 4 InstrStart pulses, halt on RUN cycle 20, DumpReady=1 -> CpuResetN low 2 cycles, 24 contiguous beats (8 reg, 15 mem, summary=0x0004), CycleCount=20, Done=1, Timeout=0.
- Unloaded memory: mem[0]=0x0000 -> ERROR one cycle after CHECK, Error=1, no DumpValid, Busy=0; Start restarts and reaches RUN with a loaded memory.
- Watchdog: WatchdogCycles=50, no halt -> Timeout=1, CycleCount=50, full dump follows. Halt on cycle 50 -> Timeout=0.
- Backpressure: DumpReady toggled 1-of-3 cycles -> every beat delivered once in order, Dump* stable while stalled, indices 0..7 and 0..14.
- Async reset mid-dump at beat 10 -> all outputs at reset values immediately, state IDLE; a new Start performs a complete clean run.
- Start during Busy ignored; saturating counters with CountWidth=4 stop at 0xF.

Source files
------------

// File: rtl/cpu_run_monitor.sv
// ---------------------------------------------------------------------------
// cpu_run_monitor
//
// Run controller and post-mortem dumper for the A09 CPU. It resets the
// CPU, waits for its control matrix to report ready, and checks that program
// memory holds something at address 0. It then lets the CPU run while it
// counts cycles and fetched instructions, until Halt or a watchdog expiry.
// Finally it streams the register file, the first MemDumpDepth memory words
// and a summary word over a valid/ready port.
//
// Ports
//   Clk, Reset        rising-edge clock, asynchronous active-high reset
//   Start             begin a run (honoured in IDLE, DONE and ERROR only)
//   CpuReady          CPU control matrix is ready (looked at in WAIT_READY)
//   InstrStart        one-cycle pulse per instruction fetch (counted in RUN)
//   CpuHalt           CPU halt level (looked at in RUN)
//   CpuResetN         active-low reset to the CPU
//   RegAddr/RegData   register-file read port (combinational read data)
//   MemAddr/MemData   memory read port (combinational read data)
//   DumpValid/Ready   dump stream handshake
//   DumpData/Kind/Index  dump beat: payload, 0=reg 1=mem 2=summary, index
//   Busy, Done, Error status levels; Timeout = watchdog hit in last run
//   CycleCount        RUN cycles of the last run (saturating)
//   InstrCount        InstrStart pulses seen in RUN (saturating)
// ---------------------------------------------------------------------------
module cpu_run_monitor #(
   parameter int DataWidth      = 16,
   parameter int AddrWidth      = 8,
   parameter int RegCount       = 8,
   parameter int MemDumpDepth   = 15,
   parameter int ResetHold      = 2,
   parameter int WatchdogCycles = 5000,
   parameter int CountWidth     = 32
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          Start,
   input  logic                          CpuReady,
   input  logic                          InstrStart,
   input  logic                          CpuHalt,
   output logic                          CpuResetN,
   output logic [$clog2(RegCount)-1:0]   RegAddr,
   input  logic [DataWidth-1:0]          RegData,
   output logic [AddrWidth-1:0]          MemAddr,
   input  logic [DataWidth-1:0]          MemData,
   output logic                          DumpValid,
   input  logic                          DumpReady,
   output logic [DataWidth-1:0]          DumpData,
   output logic [1:0]                    DumpKind,
   output logic [AddrWidth-1:0]          DumpIndex,
   output logic                          Busy,
   output logic                          Done,
   output logic                          Timeout,
   output logic                          Error,
   output logic [CountWidth-1:0]         CycleCount,
   output logic [CountWidth-1:0]         InstrCount
);

   localparam int RegAw = $clog2(RegCount);
   localparam int HoldW = (ResetHold > 1) ? $clog2(ResetHold) : 1;
   // The watchdog has its own counter so that a narrow CycleCount, which
   // saturates, can never keep the watchdog from firing.
   localparam int WdW   = $clog2(WatchdogCycles + 1);

   localparam logic [HoldW-1:0]     HOLD_LAST = HoldW'(ResetHold - 1);
   localparam logic [WdW-1:0]       WD_LAST   = WdW'(WatchdogCycles - 1);
   localparam logic [RegAw-1:0]     REG_LAST  = RegAw'(RegCount - 1);
   localparam logic [AddrWidth-1:0] MEM_LAST  = AddrWidth'(MemDumpDepth - 1);

   localparam logic [1:0] KIND_REG = 2'd0;
   localparam logic [1:0] KIND_MEM = 2'd1;
   localparam logic [1:0] KIND_SUM = 2'd2;

   typedef enum logic [3:0] {
      S_IDLE,
      S_HOLD,
      S_WAIT_READY,
      S_CHECK,
      S_RUN,
      S_DUMP_REG,
      S_DUMP_MEM,
      S_DUMP_SUM,
      S_DONE,
      S_ERROR
   } state_t;

   state_t           state;
   logic [HoldW-1:0] hold_cnt;
   logic [WdW-1:0]   wd_cnt;
   logic             sum_loaded;   // summary beat sits in the output register
   logic             load;         // output register free for a new beat

   function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] v);
      return (&v) ? v : v + CountWidth'(1);
   endfunction

   // Summary payload is the low DataWidth bits of InstrCount, zero-extended
   // when the counter is narrower than the data path.
   function automatic logic [DataWidth-1:0] summary_word(input logic [CountWidth-1:0] v);
      return DataWidth'(v);
   endfunction

   assign load = !DumpValid || DumpReady;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= S_IDLE;
         hold_cnt   <= '0;
         wd_cnt     <= '0;
         sum_loaded <= 1'b0;
         CpuResetN  <= 1'b0;
         RegAddr    <= '0;
         MemAddr    <= '0;
         DumpValid  <= 1'b0;
         DumpData   <= '0;
         DumpKind   <= KIND_REG;
         DumpIndex  <= '0;
         Busy       <= 1'b0;
         Done       <= 1'b0;
         Timeout    <= 1'b0;
         Error      <= 1'b0;
         CycleCount <= '0;
         InstrCount <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (Start) begin
                  state      <= S_HOLD;
                  hold_cnt   <= '0;
                  wd_cnt     <= '0;
                  CpuResetN  <= 1'b0;
                  Busy       <= 1'b1;
                  Done       <= 1'b0;
                  Error      <= 1'b0;
                  Timeout    <= 1'b0;
                  CycleCount <= '0;
                  InstrCount <= '0;
               end
            end

            S_HOLD: begin
               // Release the CPU exactly ResetHold cycles after Start.
               if (hold_cnt == HOLD_LAST) begin
                  state     <= S_WAIT_READY;
                  CpuResetN <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + HoldW'(1);
               end
            end

            S_WAIT_READY: begin
               if (CpuReady) begin
                  state   <= S_CHECK;
                  MemAddr <= '0;
               end
            end

            S_CHECK: begin
               // An all-zero word at address 0 means nothing was loaded.
               if (MemData == '0) begin
                  state <= S_ERROR;
                  Error <= 1'b1;
                  Busy  <= 1'b0;
               end else begin
                  state   <= S_RUN;
                  RegAddr <= '0;
               end
            end

            S_RUN: begin
               CycleCount <= sat_inc(CycleCount);
               wd_cnt     <= wd_cnt + WdW'(1);
               if (InstrStart) begin
                  InstrCount <= sat_inc(InstrCount);
               end
               // Halt beats a simultaneous watchdog expiry. Register 0 is
               // loaded on the exit edge so the first beat is valid on the
               // very next cycle.
               if (CpuHalt || (wd_cnt == WD_LAST)) begin
                  state     <= S_DUMP_REG;
                  Timeout   <= !CpuHalt;
                  DumpValid <= 1'b1;
                  DumpData  <= RegData;
                  DumpKind  <= KIND_REG;
                  DumpIndex <= AddrWidth'(RegAddr);
                  RegAddr   <= RegAddr + RegAw'(1);
                  MemAddr   <= '0;
               end
            end

            S_DUMP_REG: begin
               if (load) begin
                  DumpValid <= 1'b1;
                  DumpData  <= RegData;
                  DumpKind  <= KIND_REG;
                  DumpIndex <= AddrWidth'(RegAddr);
                  if (RegAddr == REG_LAST) begin
                     state <= S_DUMP_MEM;
                  end else begin
                     RegAddr <= RegAddr + RegAw'(1);
                  end
               end
            end

            S_DUMP_MEM: begin
               if (load) begin
                  DumpValid <= 1'b1;
                  DumpData  <= MemData;
                  DumpKind  <= KIND_MEM;
                  DumpIndex <= MemAddr;
                  if (MemAddr == MEM_LAST) begin
                     state <= S_DUMP_SUM;
                  end else begin
                     MemAddr <= MemAddr + AddrWidth'(1);
                  end
               end
            end

            S_DUMP_SUM: begin
               if (!sum_loaded) begin
                  if (load) begin
                     sum_loaded <= 1'b1;
                     DumpValid  <= 1'b1;
                     DumpData   <= summary_word(InstrCount);
                     DumpKind   <= KIND_SUM;
                     DumpIndex  <= '0;
                  end
               end else if (DumpReady) begin
                  // Summary beat accepted: stream is complete.
                  sum_loaded <= 1'b0;
                  DumpValid  <= 1'b0;
                  state      <= S_DONE;
                  Busy       <= 1'b0;
                  Done       <= 1'b1;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_monitor
//
// Bench for cpu_run_monitor. Two instances share stimulus: u_dut with a
// 32-bit counter width and u_sat with 4-bit counters. Both use a 50-cycle
// watchdog. Expected dump beats for both are queued when the bench drives
// Halt (or reaches the watchdog cycle) and are checked as the DUT presents
// them.
// ---------------------------------------------------------------------------
module tb_cpu_run_monitor;

   localparam int DW = 16;
   localparam int AW = 8;
   localparam int RC = 8;
   localparam int MD = 15;
   localparam int RH = 2;
   localparam int WD = 50;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   logic Start = 1'b0;
   logic CpuReady = 1'b0;
   logic InstrStart = 1'b0;
   logic CpuHalt = 1'b0;
   logic DumpReady = 1'b1;

   logic [DW-1:0] regs [RC];
   logic [DW-1:0] mem  [256];

   // main instance
   logic          rstn1, valid1, busy1, done1, timeout1, error1;
   logic [2:0]    regaddr1;
   logic [AW-1:0] memaddr1, index1;
   logic [DW-1:0] regdata1, memdata1, data1;
   logic [1:0]    kind1;
   logic [31:0]   cyc1, inst1;

   // 4-bit counter instance
   logic          rstn2, valid2, busy2, done2, timeout2, error2;
   logic [2:0]    regaddr2;
   logic [AW-1:0] memaddr2, index2;
   logic [DW-1:0] regdata2, memdata2, data2;
   logic [1:0]    kind2;
   logic [3:0]    cyc2, inst2;

   assign regdata1 = regs[regaddr1];
   assign memdata1 = mem[memaddr1];
   assign regdata2 = regs[regaddr2];
   assign memdata2 = mem[memaddr2];

   int n_cmp = 0;
   int n_bad = 0;
   int beats_rx = 0;
   int tick = 0;
   bit bp_mode = 1'b0;

   // {sat-instance data, kind, index, main-instance data}
   logic [41:0] sb_q [$];

   always #5 Clk = ~Clk;

   cpu_run_monitor #(
      .DataWidth(DW), .AddrWidth(AW), .RegCount(RC), .MemDumpDepth(MD),
      .ResetHold(RH), .WatchdogCycles(WD), .CountWidth(32)
   ) u_dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .CpuReady(CpuReady),
      .InstrStart(InstrStart), .CpuHalt(CpuHalt), .CpuResetN(rstn1),
      .RegAddr(regaddr1), .RegData(regdata1), .MemAddr(memaddr1),
      .MemData(memdata1), .DumpValid(valid1), .DumpReady(DumpReady),
      .DumpData(data1), .DumpKind(kind1), .DumpIndex(index1), .Busy(busy1),
      .Done(done1), .Timeout(timeout1), .Error(error1), .CycleCount(cyc1),
      .InstrCount(inst1)
   );

   cpu_run_monitor #(
      .DataWidth(DW), .AddrWidth(AW), .RegCount(RC), .MemDumpDepth(MD),
      .ResetHold(RH), .WatchdogCycles(WD), .CountWidth(4)
   ) u_sat (
      .Clk(Clk), .Reset(Reset), .Start(Start), .CpuReady(CpuReady),
      .InstrStart(InstrStart), .CpuHalt(CpuHalt), .CpuResetN(rstn2),
      .RegAddr(regaddr2), .RegData(regdata2), .MemAddr(memaddr2),
      .MemData(memdata2), .DumpValid(valid2), .DumpReady(DumpReady),
      .DumpData(data2), .DumpKind(kind2), .DumpIndex(index2), .Busy(busy2),
      .Done(done2), .Timeout(timeout2), .Error(error2), .CycleCount(cyc2),
      .InstrCount(inst2)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int sat15(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   task automatic fill_data(input logic [DW-1:0] word0);
      for (int i = 0; i < RC; i++) regs[i] = DW'($urandom);
      for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
      mem[0] = word0;
   endtask

   task automatic push_expect(input int instr);
      logic [DW-1:0] s2;
      s2 = DW'(sat15(instr));
      for (int i = 0; i < RC; i++) sb_q.push_back({regs[i], 2'd0, 8'(i), regs[i]});
      for (int i = 0; i < MD; i++) sb_q.push_back({mem[i], 2'd1, 8'(i), mem[i]});
      sb_q.push_back({s2, 2'd2, 8'd0, DW'(instr)});
   endtask

   // Dump sink ready: always high, or high one cycle in three.
   initial begin
      forever begin
         @(posedge Clk);
         #1;
         tick++;
         DumpReady = bp_mode ? (tick % 3 == 0) : 1'b1;
      end
   end

   // Scoreboard: every presented beat must match the queue head, including
   // each cycle it is stalled; it is retired when DumpReady is high.
   initial begin
      forever begin
         @(negedge Clk);
         if (!Reset && valid1) begin
            check_val("sb_has_beat", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
               check_val("beat_main", {kind1, index1, data1}, sb_q[0][25:0]);
               check_val("beat_sat", {valid2, kind2, index2, data2},
                         {1'b1, sb_q[0][25:16], sb_q[0][41:26]});
               if (DumpReady) begin
                  void'(sb_q.pop_front());
                  beats_rx++;
               end
            end
         end
      end
   end

   // Drives one run up to the cycle after the RUN exit edge (or after the
   // ERROR entry edge). halt_cyc = 0 means never halt.
   task automatic do_run(input int ready_delay, input int halt_cyc, input int n_instr,
                         input bit exp_err, input bit start_mid);
      int low_cnt;
      int c;
      int pulses;
      bit fin;
      bit exp_to;
      beats_rx = 0;
      @(posedge Clk); #1;
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      check_val("busy_hold", busy1, 1);
      check_val("flags_cleared", {done1, error1, timeout1}, 0);
      check_val("cyc_cleared", cyc1, 0);
      // Halt and fetch pulses outside RUN must be ignored.
      CpuHalt = 1'b1;
      InstrStart = 1'b1;
      low_cnt = 0;
      for (int i = 0; i < 20 && rstn1 == 1'b0; i++) begin
         low_cnt++;
         @(posedge Clk); #1;
      end
      check_val("rstn_low_cycles", low_cnt, RH);
      repeat (ready_delay) begin
         @(posedge Clk); #1;
      end
      CpuReady = 1'b1;
      CpuHalt = 1'b0;
      InstrStart = 1'b0;
      @(posedge Clk); #1;
      CpuReady = 1'b0;
      check_val("check_memaddr", memaddr1, 0);
      @(posedge Clk); #1;
      if (exp_err) begin
         check_val("error_state", {error1, busy1, valid1, rstn1, done1}, 5'b10010);
         check_val("error_sat", error2, 1);
         return;
      end
      check_val("run_cyc_start", cyc1, 0);
      c = 1;
      pulses = 0;
      fin = 1'b0;
      exp_to = 1'b0;
      while (!fin) begin
         InstrStart = (c % 2 == 0) && (pulses < n_instr);
         if (InstrStart) pulses++;
         CpuHalt = (c == halt_cyc);
         Start = start_mid && (c == 10);
         if (CpuHalt || c == WD) begin
            exp_to = !CpuHalt;
            push_expect(pulses);
            fin = 1'b1;
         end
         @(posedge Clk); #1;
         InstrStart = 1'b0;
         CpuHalt = 1'b0;
         Start = 1'b0;
         if (!fin) c++;
      end
      check_val("halt_to_valid", valid1, 1);
      check_val("cycle_count", cyc1, c);
      check_val("instr_count", inst1, pulses);
      check_val("timeout", timeout1, exp_to);
      check_val("cycle_count_sat", cyc2, sat15(c));
      check_val("instr_count_sat", inst2, sat15(pulses));
      check_val("timeout_sat", timeout2, exp_to);
   endtask

   task automatic wait_done(input bit no_bp);
      int n;
      int vcnt;
      n = 0;
      vcnt = 0;
      while (!done1 && n < 600) begin
         if (valid1) vcnt++;
         @(posedge Clk); #1;
         n++;
      end
      check_val("done", done1, 1);
      check_val("done_sat", done2, 1);
      check_val("idle_at_done", {busy1, valid1, rstn1}, 3'b001);
      check_val("beats_rx", beats_rx, RC + MD + 1);
      check_val("sb_empty", sb_q.size(), 0);
      if (no_bp) begin
         check_val("dump_cycles", n, RC + MD + 1);
         check_val("valid_cycles", vcnt, RC + MD + 1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1);
   end

   initial begin
      int n;
      fill_data(16'h1234);
      repeat (3) @(posedge Clk);
      #1;
      check_val("rst_flags", {rstn1, valid1, busy1, done1, timeout1, error1}, 0);
      check_val("rst_counts", {cyc1, inst1}, 0);
      check_val("rst_dump", {kind1, index1, data1}, 0);
      check_val("rst_addr", {regaddr1, memaddr1}, 0);
      check_val("rst_sat", {rstn2, valid2, busy2, done2, cyc2, inst2}, 0);
      Reset = 1'b0;

      // Normal run
      fill_data(16'h1234);
      do_run(3, 20, 4, 1'b0, 1'b0);
      wait_done(1'b1);

      // Unloaded memory, then a restart with loaded memory
      fill_data(16'h0000);
      do_run(1, 0, 0, 1'b1, 1'b0);
      check_val("error_hold", {error1, busy1}, 2'b10);
      mem[0] = 16'h55AA;
      do_run(2, 7, 2, 1'b0, 1'b0);
      check_val("error_cleared", error1, 0);
      wait_done(1'b1);

      // Watchdog expiry with a Start pulse during RUN, then halt on cycle 50
      fill_data(16'hBEEF);
      do_run(0, 0, 3, 1'b0, 1'b1);
      wait_done(1'b1);
      fill_data(16'h0F0F);
      do_run(0, WD, 3, 1'b0, 1'b0);
      wait_done(1'b1);

      // Backpressure
      fill_data(16'hCAFE);
      bp_mode = 1'b1;
      do_run(2, 12, 5, 1'b0, 1'b0);
      wait_done(1'b0);
      bp_mode = 1'b0;

      // Counter saturation on the 4-bit instance
      fill_data(16'h7777);
      do_run(1, 45, 20, 1'b0, 1'b0);
      wait_done(1'b1);

      // Asynchronous reset in the middle of the dump
      fill_data(16'h0BEE);
      do_run(1, 6, 2, 1'b0, 1'b0);
      n = 0;
      while (beats_rx < 10 && n < 100) begin
         @(negedge Clk); #2;
         n++;
      end
      check_val("beats_before_reset", beats_rx, 10);
      Reset = 1'b1;
      #1;
      check_val("arst_flags", {rstn1, valid1, busy1, done1, timeout1, error1}, 0);
      check_val("arst_counts", {cyc1, inst1}, 0);
      check_val("arst_dump", {kind1, index1, data1}, 0);
      check_val("arst_addr", {regaddr1, memaddr1}, 0);
      check_val("arst_sat", {valid2, busy2, cyc2, inst2}, 0);
      sb_q.delete();
      @(posedge Clk); #3;
      Reset = 1'b0;
      fill_data(16'h4321);
      do_run(2, 9, 3, 1'b0, 1'b0);
      wait_done(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
